// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_pkg
// Description : Shared types and constants for the fetch sequencer slice:
//               state encoding, bubble instruction, reset PC and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

    // Fetch controller state encoding
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_BOOT  = 2'd0;
    localparam fetch_state_t ST_FETCH = 2'd1;
    localparam fetch_state_t ST_WAIT  = 2'd2;
    localparam fetch_state_t ST_HOLD  = 2'd3;

    // Instruction addresses are word aligned; low bits of a target are dropped
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_load_use.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard compare between the ID-stage
//               source registers and the destination of a load in EX.
//               Shared with the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import fetch_sequencer_pkg::*;
(
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic [4:0] i_rd,
    input  logic       i_mem_read,
    output logic       o_hazard
);

    // x0 is never a real producer, so a load targeting it cannot cause a stall
    assign o_hazard = i_mem_read && (i_rd != 5'd0) && ((i_rd == i_rs1) || (i_rd == i_rs2));

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Fetch-side controller. Owns the PC, issues single-outstanding
//               instruction memory requests and drives the IF/ID register
//               inputs, stalling by holding its outputs and bubbling with NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR   = DEF_NOP_INSTR,
    parameter int          STALL_CNT_W = 16
)(
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   ex_redirect,
    input  logic [31:0]            ex_target,
    output logic [31:0]            fetch_instr,
    output logic [31:0]            fetch_pc,
    output logic                   fetch_valid,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [STALL_CNT_W-1:0] C_STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    fetch_state_t           r_state;
    logic [31:0]            r_pc;
    logic                   r_drop;
    logic [31:0]            r_hold_instr;
    logic [31:0]            r_hold_pc;
    logic                   r_imem_req;
    logic [31:0]            r_imem_addr;
    logic [31:0]            r_fetch_instr;
    logic [31:0]            r_fetch_pc;
    logic                   r_fetch_valid;
    logic [STALL_CNT_W-1:0] r_stall_count;

    logic                   w_hazard;
    fetch_state_t           w_state_nxt;
    logic [31:0]            w_pc_nxt;
    logic                   w_drop_nxt;
    logic                   w_hold_load;
    logic                   w_hold_clear;
    logic                   w_emit;
    logic [31:0]            w_emit_instr;
    logic [31:0]            w_emit_pc;

    load_use_detect u_load_use (
        .i_rs1      (id_rs1),
        .i_rs2      (id_rs2),
        .i_rd       (ex_rd),
        .i_mem_read (ex_mem_read),
        .o_hazard   (w_hazard)
    );

    // Next-state / PC decision; a redirect overrides every other event
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_drop_nxt   = r_drop;
        w_hold_load  = 1'b0;
        w_hold_clear = 1'b0;
        w_emit       = 1'b0;
        w_emit_instr = r_hold_instr;
        w_emit_pc    = r_hold_pc;
        if (ex_redirect) begin
            w_pc_nxt     = word_align(ex_target);
            w_hold_clear = 1'b1;
            case (r_state)
                ST_FETCH: begin
                    // request goes out this cycle; its response must be thrown away
                    w_state_nxt = ST_WAIT;
                    w_drop_nxt  = 1'b1;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        w_state_nxt = ST_FETCH;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = ST_FETCH;
            endcase
        end else begin
            case (r_state)
                ST_BOOT:  w_state_nxt = ST_FETCH;
                ST_FETCH: w_state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_drop) begin
                            w_drop_nxt  = 1'b0;
                            w_state_nxt = ST_FETCH;
                        end else if (w_hazard) begin
                            w_hold_load = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end else begin
                            w_emit       = 1'b1;
                            w_emit_instr = imem_rdata;
                            w_emit_pc    = r_pc;
                            w_pc_nxt     = r_pc + 32'd4;
                            w_state_nxt  = ST_FETCH;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!w_hazard) begin
                        w_emit      = 1'b1;
                        w_pc_nxt    = r_pc + 32'd4;
                        w_state_nxt = ST_FETCH;
                    end
                end
                default: w_state_nxt = ST_BOOT;
            endcase
        end
    end

    // Controller state, PC, drop flag and the load-use hold buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_drop       <= 1'b0;
            r_hold_instr <= 32'd0;
            r_hold_pc    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_drop  <= w_drop_nxt;
            if (w_hold_clear) begin
                r_hold_instr <= 32'd0;
                r_hold_pc    <= 32'd0;
            end else if (w_hold_load) begin
                r_hold_instr <= imem_rdata;
                r_hold_pc    <= r_pc;
            end
        end
    end

    // Request pulse is raised on entry to FETCH so it is visible for that whole state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
        end else begin
            r_imem_req <= (w_state_nxt == ST_FETCH);
            if (w_state_nxt == ST_FETCH) begin
                r_imem_addr <= w_pc_nxt;
            end
        end
    end

    // IF/ID drive: redirect bubbles, hazard freezes, otherwise emit or bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_instr <= NOP_INSTR;
            r_fetch_pc    <= RESET_PC;
            r_fetch_valid <= 1'b0;
        end else if (ex_redirect) begin
            r_fetch_instr <= NOP_INSTR;
            r_fetch_valid <= 1'b0;
        end else if (w_hazard) begin
            // hold everything so the IF/ID register re-latches the same word
        end else if (w_emit) begin
            r_fetch_instr <= w_emit_instr;
            r_fetch_pc    <= w_emit_pc;
            r_fetch_valid <= 1'b1;
        end else begin
            r_fetch_instr <= NOP_INSTR;
            r_fetch_valid <= 1'b0;
        end
    end

    // Saturating count of cycles lost to load-use stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_hazard && !ex_redirect && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + C_STALL_ONE;
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign fetch_instr = r_fetch_instr;
    assign fetch_pc    = r_fetch_pc;
    assign fetch_valid = r_fetch_valid;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer. A memory responder
//               with variable latency feeds a scoreboard of instructions that
//               must reach IF/ID; a monitor checks the IF/ID drive each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam logic [31:0] C_RST_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [4:0]  id_rs1 = 5'd0;
    logic [4:0]  id_rs2 = 5'd0;
    logic [4:0]  ex_rd = 5'd0;
    logic        ex_mem_read = 1'b0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_target = 32'd0;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC    (C_RST_PC),
        .NOP_INSTR   (C_NOP),
        .STALL_CNT_W (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .fetch_instr (fetch_instr),
        .fetch_pc    (fetch_pc),
        .fetch_valid (fetch_valid),
        .stall_count (stall_count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    int          checks = 0;
    int          errors = 0;
    item_t       sb_q[$];
    int          req_cycles[$];
    int          cyc = 0;
    int          emit_count = 0;
    logic        mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'd0;
    logic        mem_stale = 1'b0;
    int          next_lat = 1;
    logic [31:0] req_next = C_RST_PC;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic spec_hazard();
        return ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    endfunction

    // One cycle of stimulus: memory responder, hazard fields and redirect
    task automatic step(input logic haz, input logic redir, input logic [31:0] tgt);
        item_t it;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                mem_pend    = 1'b0;
                if (!mem_stale) begin
                    it.pc    = mem_addr;
                    it.instr = mem_word(mem_addr);
                    sb_q.push_back(it);
                end
            end
        end
        if (imem_req) begin
            check("single_outstanding", {31'd0, mem_pend}, 32'd0);
            check("imem_addr", imem_addr, req_next);
            req_cycles.push_back(cyc);
            mem_pend  = 1'b1;
            mem_cnt   = next_lat;
            mem_addr  = imem_addr;
            mem_stale = 1'b0;
            req_next  = imem_addr + 32'd4;
        end
        if (haz) begin
            ex_mem_read = 1'b1;
            ex_rd       = 5'($urandom_range(1, 31));
            id_rs1      = 5'($urandom_range(0, 31));
            id_rs2      = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) id_rs1 = ex_rd;
            else                           id_rs2 = ex_rd;
        end else begin
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_rd       = 5'($urandom_range(0, 31));
            id_rs1      = 5'($urandom_range(0, 31));
            id_rs2      = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) begin
                ex_mem_read = 1'b1;
                ex_rd       = 5'd0;
                id_rs1      = 5'd0;
            end
            if (spec_hazard()) ex_mem_read = 1'b0;
        end
        ex_redirect = redir;
        ex_target   = tgt;
        if (redir) begin
            sb_q.delete();
            if (mem_pend) mem_stale = 1'b1;
            req_next = {tgt[31:2], 2'b00};
        end
    endtask

    // Pulse reset for one cycle; a response still in flight shows up as a stray strobe
    task automatic apply_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        ex_redirect = 1'b0;
        ex_mem_read = 1'b0;
        imem_rvalid = 1'b0;
        sb_q.delete();
        req_cycles.delete();
        req_next  = C_RST_PC;
        mem_stale = 1'b1;
        #1;
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, C_RST_PC);
        check("rst_fetch_instr", fetch_instr, C_NOP);
        check("rst_fetch_pc", fetch_pc, C_RST_PC);
        check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_stall_count", {16'd0, stall_count}, 32'd0);
        @(negedge clk);
        if (mem_pend) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            mem_pend    = 1'b0;
        end
        rst_n = 1'b1;
    endtask

    // Wait (bounded) until a request has just been accepted by the responder
    task automatic wait_new_req(input int lat);
        int n;
        n = 0;
        next_lat = lat;
        while (!(mem_pend && mem_cnt == lat) && n < 20) begin
            step(1'b0, 1'b0, 32'd0);
            n++;
        end
        if (n >= 20) check("wait_req_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: predicts the IF/ID drive from the scoreboard and the inputs seen at each edge
    initial begin : monitor
        logic        s_rst;
        logic        s_red;
        logic        s_haz;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic [15:0] exp_stall;
        item_t       it;
        exp_instr = C_NOP;
        exp_pc    = C_RST_PC;
        exp_valid = 1'b0;
        exp_stall = 16'd0;
        forever begin
            @(posedge clk);
            s_rst = rst_n;
            s_red = ex_redirect;
            s_haz = spec_hazard();
            if (rst_n) cyc++;
            else       cyc = 0;
            #1;
            if (!s_rst) begin
                exp_instr = C_NOP;
                exp_pc    = C_RST_PC;
                exp_valid = 1'b0;
                exp_stall = 16'd0;
            end else if (s_red) begin
                exp_instr = C_NOP;
                exp_valid = 1'b0;
            end else if (s_haz) begin
                if (exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
            end else if (sb_q.size() != 0) begin
                it        = sb_q.pop_front();
                exp_instr = it.instr;
                exp_pc    = it.pc;
                exp_valid = 1'b1;
                emit_count++;
            end else begin
                exp_instr = C_NOP;
                exp_valid = 1'b0;
            end
            check("fetch_valid", {31'd0, fetch_valid}, {31'd0, exp_valid});
            check("fetch_instr", fetch_instr, exp_instr);
            check("fetch_pc", fetch_pc, exp_pc);
            check("stall_count", {16'd0, stall_count}, {16'd0, exp_stall});
        end
    end

    // Stimulus: directed scenarios followed by a randomized run
    initial begin : stimulus
        logic [31:0] tgt;
        logic        haz;
        logic        red;
        repeat (2) @(negedge clk);
        apply_reset();

        // Back-to-back fetches with single-cycle memory: requests at cycles 1, 3, 5
        next_lat = 1;
        repeat (10) step(1'b0, 1'b0, 32'd0);
        if (req_cycles.size() >= 3) begin
            check("req_cycle_0", 32'(req_cycles[0]), 32'd1);
            check("req_cycle_1", 32'(req_cycles[1]), 32'd3);
            check("req_cycle_2", 32'(req_cycles[2]), 32'd5);
        end else begin
            check("req_cycle_count", 32'(req_cycles.size()), 32'd3);
        end

        // Load-use stall lasting 3 cycles across the response
        apply_reset();
        wait_new_req(1);
        repeat (3) step(1'b1, 1'b0, 32'd0);
        repeat (3) step(1'b0, 1'b0, 32'd0);
        check("loaduse_stall_count", {16'd0, stall_count}, 32'd3);

        // Redirect while waiting on a slow response
        wait_new_req(3);
        step(1'b0, 1'b1, 32'h0000_0100);
        repeat (8) step(1'b0, 1'b0, 32'd0);

        // Redirect and hazard together, misaligned target, PC wrap
        step(1'b1, 1'b1, 32'h0000_0100);
        repeat (4) step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h0000_0103);
        repeat (4) step(1'b0, 1'b0, 32'd0);
        next_lat = 1;
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        repeat (8) step(1'b0, 1'b0, 32'd0);

        // Reset while a response is outstanding
        wait_new_req(3);
        step(1'b0, 1'b0, 32'd0);
        apply_reset();
        next_lat = 1;
        repeat (6) step(1'b0, 1'b0, 32'd0);
        if (req_cycles.size() >= 1) check("restart_req_cycle", 32'(req_cycles[0]), 32'd1);
        else                        check("restart_req_count", 32'd0, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            next_lat = $urandom_range(1, 4);
            haz = ($urandom_range(0, 4) == 0);
            red = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                1:       tgt = $urandom;
                default: tgt = {20'd0, 12'($urandom)};
            endcase
            step(haz, red, tgt);
        end
        repeat (10) step(1'b0, 1'b0, 32'd0);

        check("emit_progress", {31'd0, emit_count > 100}, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the fetch side of the pipeline: owns the PC, issues instruction-memory requests and drives the instruction/PC/valid inputs of the IF/ID pipeline register.
- The IF/ID register has no enable, so this block performs stalls by holding its registered outputs, and bubbles by driving NOP.
- Sits between instruction memory, the IF/ID register, the ID-stage hazard comparators and the EX-stage branch/jump resolution.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  one-cycle request pulse.
- imem_addr  out  32  fetch address, valid while imem_req=1.
- imem_rvalid  in  1  response strobe, arriving 1 or more cycles after imem_req.
- imem_rdata  in  32  instruction, valid with imem_rvalid.
- id_rs1  in  5  ID-stage source register 1.
- id_rs2  in  5  ID-stage source register 2.
- ex_rd  in  5  EX-stage destination register.
- ex_mem_read  in  1  EX-stage instruction is a load.
- ex_redirect  in  1  taken branch/jump resolved in EX.
- ex_target  in  32  redirect address.
- fetch_instr  out  32  drives IF/ID instruction_in.
- fetch_pc  out  32  PC of fetch_instr.
- fetch_valid  out  1  fetch_instr is a real instruction.
- stall_count  out  STALL_CNT_W  saturating load-use stall counter.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=BOOT, imem_req=0, imem_addr=RESET_PC.
  - fetch_instr=NOP_INSTR, fetch_pc=RESET_PC, fetch_valid=0.
  - drop=0, hold buffer cleared, stall_count=0.
- Reset asserted mid-transaction: an outstanding response is forgotten. Any imem_rvalid arriving before the first new request is ignored.
- hazard = ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
- All outputs are registered. One request may be outstanding at a time.
- State transitions:
  - BOOT -> FETCH after one cycle.
  - FETCH: imem_req=1, imem_addr=pc; go to WAIT. The request issues regardless of hazard.
  - WAIT, no rvalid: stay in WAIT.
  - WAIT, rvalid with drop=1: discard the response, clear drop, go to FETCH.
  - WAIT, rvalid with hazard=1: store rdata/pc in the hold buffer, go to HOLD.
  - WAIT, rvalid otherwise: next edge sets fetch_instr=rdata, fetch_pc=pc, fetch_valid=1; pc+=4; go to FETCH.
  - HOLD, hazard=1: stay in HOLD.
  - HOLD, hazard=0: emit the buffer (same rules as WAIT emit), pc+=4, go to FETCH.
- Stall rule: whenever hazard=1, fetch_instr/fetch_pc/fetch_valid keep their values, so IF/ID re-latches the same instruction.
- Redirect (ex_redirect=1) has highest priority and beats hazard in the same cycle:
  - pc={ex_target[31:2],2'b00}; misaligned low bits are forced to zero.
  - fetch_instr=NOP_INSTR, fetch_valid=0; fetch_pc is unchanged.
  - The hold buffer is cleared.
  - From FETCH (request issuing this cycle): set drop=1 and go to WAIT.
  - From WAIT without rvalid: set drop=1 and stay in WAIT.
  - From WAIT with rvalid in the same cycle: discard that response and go to FETCH.
  - From HOLD or BOOT: go to FETCH.
- Bubble after emit: in a cycle with no emit, no stall and no redirect, fetch_instr=NOP_INSTR and fetch_valid=0. fetch_pc keeps its last value.
- stall_count increments in every cycle with hazard=1 and ex_redirect=0, and saturates at all-ones.
- PC wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Peak throughput: one instruction every 2 cycles with 1-cycle memory latency.

Decomposition:
- Shared package: state enum (BOOT, FETCH, WAIT, HOLD), NOP_INSTR, RESET_PC default, XLEN=32.
- Sub-module: load_use_detect (combinational hazard compare), reused by the decode stage.
- The IF/ID register stays a separate instance fed by fetch_instr.

Test Plan:
- Reset release with RESET_PC=0 and 1-cycle memory returning 32'h00500093: imem_req at cycles 1, 3, 5; fetch_instr=32'h00500093, fetch_pc=0, valid=1 two cycles after the first req; next PCs 4, 8.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 for 3 cycles while rvalid arrives: outputs frozen 3 cycles, buffered instruction then emitted, stall_count=3.
- Redirect in WAIT, memory latency 3, ex_target=32'h100: late response dropped; next imem_addr=32'h100; fetch_valid=0 meanwhile.
- Redirect and hazard in the same cycle: redirect wins, pc=32'h100, stall_count unchanged.
- ex_target=32'h103 -> imem_addr=32'h100. PC at 32'hFFFF_FFFC -> next fetch 0.
- rst_n pulsed low while in WAIT with a pending response: outputs return to reset values immediately; the stray rvalid is ignored; fetch restarts at RESET_PC.
